// File: rtl/pipeline_scoreboard.sv
// Register-hazard scoreboard: per-register result countdowns drive stall and bypass distances.
// Optional stall statistics counter is built when SCOREBOARD_STATS_EN is defined.
module pipeline_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_LAT    = 4,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned BYPASS_MAX = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs,
  input  logic [REG_ADDR_W-1:0] issue_rt,
  input  logic                  issue_uses_rs,
  input  logic                  issue_uses_rt,
  input  logic                  issue_wr_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic                  flush,
  output logic                  stall,
  output logic [LAT_W-1:0]      fwd_rs_dist,
  output logic [LAT_W-1:0]      fwd_rt_dist,
  output logic [REG_ADDR_W:0]   busy_count,
  output logic [31:0]           stall_cycles
);

  localparam int unsigned      NumSlots = 1 << REG_ADDR_W;
  localparam int unsigned      CountW   = REG_ADDR_W + 1;
  localparam logic [LAT_W-1:0] MaxLatC  = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] BypassC  = LAT_W'(BYPASS_MAX);

  logic [LAT_W-1:0] cntQ    [NUM_REGS];
  logic [LAT_W-1:0] cntD    [NUM_REGS];
  logic [LAT_W-1:0] cntView [NumSlots];

  logic [LAT_W-1:0] latEff;
  logic             tracked;
  logic             hzRs;
  logic             hzRt;
  logic             hzWaw;
  logic             accept;

  // Full address-space view so out-of-range and zero indices read as idle.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) cntView[i] = '0;
    for (int r = 1; r < NUM_REGS; r++) cntView[r] = cntQ[r];
  end

  // Hazard detection against the counters as they stand before this cycle's write.
  always_comb begin
    latEff  = (issue_lat > MaxLatC) ? MaxLatC : issue_lat;
    tracked = issue_wr_en && (issue_rd != '0) && (latEff != '0);
    hzRs    = issue_uses_rs && (issue_rs != '0) && (cntView[issue_rs] > BypassC);
    hzRt    = issue_uses_rt && (issue_rt != '0) && (cntView[issue_rt] > BypassC);
    hzWaw   = tracked && (cntView[issue_rd] >= latEff);
    stall   = issue_valid && !flush && (hzRs || hzRt || hzWaw);
    accept  = issue_valid && !flush && !stall;
  end

  always_comb begin
    fwd_rs_dist = issue_uses_rs ? cntView[issue_rs] : '0;
    fwd_rt_dist = issue_uses_rt ? cntView[issue_rt] : '0;
  end

  always_comb begin
    busy_count = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (cntQ[r] != '0) busy_count = busy_count + CountW'(1);
    end
  end

  // Older results keep draining; a newly accepted write reloads its register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cntD[r] = cntQ[r];
      if (cntQ[r] != '0) cntD[r] = cntQ[r] - LAT_W'(1);
      if (accept && tracked && (issue_rd == REG_ADDR_W'(r))) cntD[r] = latEff;
    end
    cntD[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) cntQ[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cntQ[r] <= cntD[r];
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] statQ;

  always_ff @(posedge clock) begin
    if (!reset) begin
      statQ <= '0;
    end else if (stall) begin
      statQ <= statQ + 32'd1;
    end
  end

  assign stall_cycles = statQ;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: per-cycle stimulus rows with expected
// {stall, fwd_rs_dist, fwd_rt_dist, busy_count} pushed to a scoreboard queue.
module tb_pipeline_scoreboard;

  typedef struct packed {
    logic       valid;
    logic       urs;
    logic [4:0] rs;
    logic       urt;
    logic [4:0] rt;
    logic       wr;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       fl;
    logic       rst;
    logic       eStall;
    logic [2:0] eRs;
    logic [2:0] eRt;
    logic [5:0] eBusy;
  } row_t;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_uses_rs;
  logic        issue_uses_rt;
  logic        issue_wr_en;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic        flush;
  logic        stall;
  logic [2:0]  fwd_rs_dist;
  logic [2:0]  fwd_rt_dist;
  logic [5:0]  busy_count;
  logic [31:0] stall_cycles;

  logic [12:0] expQ [$];
  int checks = 0;
  int passed = 0;

  pipeline_scoreboard dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_wr_en(issue_wr_en), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .flush(flush), .stall(stall), .fwd_rs_dist(fwd_rs_dist),
    .fwd_rt_dist(fwd_rt_dist), .busy_count(busy_count), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arguments: valid, uses_rs, rs, uses_rt, rt, wr_en, rd, lat, flush, reset,
  //            expected stall, fwd_rs, fwd_rt, busy.
  function automatic row_t mk(input int v, urs, rs, urt, rt, wr, rd, lat, fl, rst,
                              es, ers, ert, eb);
    row_t r;
    r.valid = 1'(v);   r.urs = 1'(urs); r.rs = 5'(rs);   r.urt = 1'(urt);
    r.rt = 5'(rt);     r.wr = 1'(wr);   r.rd = 5'(rd);   r.lat = 3'(lat);
    r.fl = 1'(fl);     r.rst = 1'(rst); r.eStall = 1'(es);
    r.eRs = 3'(ers);   r.eRt = 3'(ert); r.eBusy = 6'(eb);
    return r;
  endfunction

  // Drive one cycle of stimulus away from the rising edge and queue its expectation.
  task automatic apply(input row_t r);
    @(negedge clock);
    reset = r.rst;       issue_valid = r.valid;
    issue_uses_rs = r.urs; issue_rs = r.rs;
    issue_uses_rt = r.urt; issue_rt = r.rt;
    issue_wr_en = r.wr;  issue_rd = r.rd; issue_lat = r.lat; flush = r.fl;
    expQ.push_back({r.eStall, r.eRs, r.eRt, r.eBusy});
  endtask

  task automatic test_reset;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,0,0,0,0,1,5,3,0,1, 0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,1,6,4,0,1, 0,0,0,1));
    rows.push_back(mk(1,1,6,0,0,1,7,2,0,0, 1,4,0,2));
    rows.push_back(mk(1,1,6,0,0,1,7,2,0,0, 0,0,0,0));
    rows.push_back(mk(0,1,7,1,5,0,0,0,0,1, 0,0,0,0));
    rows.push_back(mk(0,1,6,0,0,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL reset row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
    checks++;
    if (stall_cycles !== 32'd0) $display("FAIL reset_stats: got %0d expected 0", stall_cycles);
    else passed++;
  endtask

  task automatic test_load_use;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,0,0,0,0,1,5,3,0,1, 0,0,0,0));
    rows.push_back(mk(1,1,5,0,0,0,0,0,0,1, 1,3,0,1));
    rows.push_back(mk(1,1,5,0,0,0,0,0,0,1, 0,2,0,1));
    rows.push_back(mk(0,1,5,0,0,0,0,0,0,1, 0,1,0,1));
    rows.push_back(mk(0,1,5,0,0,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL load_use row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_reg_zero;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,0,0,0,0,1,0,4,0,1, 0,0,0,0));
    rows.push_back(mk(1,1,0,1,0,1,0,4,0,1, 0,0,0,0));
    rows.push_back(mk(0,1,0,0,0,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL reg_zero row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
  endtask

  // Latency 7 clamps to 4; latency 0 tracks nothing.
  task automatic test_clamp;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,0,0,0,0,1,3,7,0,1, 0,0,0,0));
    rows.push_back(mk(1,1,3,0,0,0,0,0,0,1, 1,4,0,1));
    rows.push_back(mk(1,1,3,0,0,0,0,0,0,1, 1,3,0,1));
    rows.push_back(mk(1,1,3,0,0,0,0,0,0,1, 0,2,0,1));
    rows.push_back(mk(1,1,3,0,0,1,8,0,0,1, 0,1,0,1));
    rows.push_back(mk(0,1,8,1,3,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL clamp row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_waw;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,0,0,0,0,1,7,4,0,1, 0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,1,7,1,0,1, 1,0,0,1));
    rows.push_back(mk(1,0,0,0,0,1,7,1,0,1, 1,0,0,1));
    rows.push_back(mk(1,0,0,0,0,1,7,1,0,1, 1,0,0,1));
    rows.push_back(mk(1,0,0,0,0,1,7,1,0,1, 1,0,0,1));
    rows.push_back(mk(1,0,0,0,0,1,7,1,0,1, 0,0,0,0));
    rows.push_back(mk(0,1,7,0,0,0,0,0,0,1, 0,1,0,1));
    rows.push_back(mk(0,1,7,0,0,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL waw row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_flush;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,0,0,0,0,1,4,3,0,1, 0,0,0,0));
    rows.push_back(mk(1,1,4,0,0,1,9,3,1,1, 0,3,0,1));
    rows.push_back(mk(1,1,4,0,0,1,9,3,1,1, 0,2,0,1));
    rows.push_back(mk(0,1,9,1,4,0,0,0,0,1, 0,0,1,1));
    rows.push_back(mk(0,0,0,0,0,1,9,3,1,1, 0,0,0,0));
    rows.push_back(mk(0,1,9,0,0,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL flush row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
  endtask

  // Consecutive accepts, including sources that name the instruction's own destination.
  task automatic test_back_to_back;
    row_t rows[$];
    logic [12:0] e;
    logic [12:0] o;
    rows.push_back(mk(1,1,2,0,0,1,2,2,0,1, 0,0,0,0));
    rows.push_back(mk(1,0,0,1,2,1,10,1,0,1, 0,0,2,1));
    rows.push_back(mk(1,1,2,1,10,1,2,4,0,1, 0,1,1,2));
    rows.push_back(mk(0,1,2,0,0,0,0,0,0,1, 0,4,0,1));
    rows.push_back(mk(0,1,2,0,0,0,0,0,0,1, 0,3,0,1));
    rows.push_back(mk(0,1,2,0,0,0,0,0,0,1, 0,2,0,1));
    rows.push_back(mk(0,1,2,0,0,0,0,0,0,1, 0,1,0,1));
    rows.push_back(mk(0,1,2,1,10,0,0,0,0,1, 0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      #1;
      e = expQ.pop_front();
      o = {stall, fwd_rs_dist, fwd_rt_dist, busy_count};
      checks++;
      if (o !== e) $display("FAIL back_to_back row %0d: got %h expected %h", i, o, e);
      else passed++;
    end
  endtask

  // One stall in load-use, two in clamp, four in WAW; reset-time stalls are not counted.
  task automatic test_stats;
    logic [31:0] expStat;
`ifdef SCOREBOARD_STATS_EN
    expStat = 32'd7;
`else
    expStat = 32'd0;
`endif
    @(negedge clock);
    checks++;
    if (stall_cycles !== expStat)
      $display("FAIL stats: got %0d expected %0d", stall_cycles, expStat);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_rs = '0; issue_rt = '0;
    issue_uses_rs = 1'b0; issue_uses_rt = 1'b0; issue_wr_en = 1'b0;
    issue_rd = '0; issue_lat = '0; flush = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_load_use();
    test_reg_zero();
    test_clamp();
    test_waw();
    test_flush();
    test_back_to_back();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the pipelined core.
- Generalises the fixed load-use hazard unit to variable result latency per instruction, with a configurable bypass depth and register count.
- Sits between decode (ID) and the ID/EX register. Tracks every in-flight destination register with a countdown.
- Drives the pipeline stall and the bypass-distance selects used by the forwarding muxes.

Parameters:
- NUM_REGS, 32, number of architectural registers (register 0 is hard-wired zero).
- REG_ADDR_W, 5, register index width; NUM_REGS <= 2^REG_ADDR_W.
- MAX_LAT, 4, largest result latency in cycles; issue_lat values above this are clamped to it.
- LAT_W, 3, counter width; must hold MAX_LAT.
- BYPASS_MAX, 2, largest remaining count at which a source can still be bypassed instead of stalled.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- issue_valid  in  1  a decoded instruction is presented in ID.
- issue_rs  in  REG_ADDR_W  source register A.
- issue_rt  in  REG_ADDR_W  source register B.
- issue_uses_rs  in  1  instruction reads rs.
- issue_uses_rt  in  1  instruction reads rt.
- issue_wr_en  in  1  instruction writes a register.
- issue_rd  in  REG_ADDR_W  destination register.
- issue_lat  in  LAT_W  cycles until the result is written back.
- flush  in  1  squash the instruction currently in ID (branch taken).
- stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.
- fwd_rs_dist  out  LAT_W  remaining count of rs (0 = read the register file).
- fwd_rt_dist  out  LAT_W  remaining count of rt (0 = read the register file).
- busy_count  out  REG_ADDR_W+1  number of registers with a nonzero counter.
- stall_cycles  out  32  stall statistics counter (see Optional Feature).

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Reset (reset==0 at a clock edge): all cnt cleared. Resulting outputs: stall=0, fwd_*_dist=0, busy_count=0, stall_cycles=0. Reset overrides issue, flush and decrement in the same cycle, including mid-operation.
- Effective latency: lat_eff = min(issue_lat, MAX_LAT).
- An instruction with issue_wr_en=0, issue_rd=0 or lat_eff=0 does not track a destination.
- Stall is combinational. stall = issue_valid && !flush && (hz_rs || hz_rt || hz_waw), where:
  - hz_rs = issue_uses_rs && issue_rs!=0 && cnt[issue_rs] > BYPASS_MAX
  - hz_rt = the same condition on rt
  - hz_waw = tracked destination && cnt[issue_rd] >= lat_eff. This keeps write-back order.
- Accept = issue_valid && !flush && !stall.
- Every cycle, each nonzero cnt decrements by 1, whether or not a stall is active, because older instructions keep advancing.
- On accept with a tracked destination, cnt[issue_rd] <= lat_eff. This overrides the decrement for that register. The new value is visible from the next cycle.
- fwd_rs_dist = cnt[issue_rs] when issue_uses_rs, else 0; it is combinational and valid whenever stall=0. fwd_rt_dist follows the same rule. Forwarding-mux encoding is owned by the datapath.
- busy_count is combinational: the population count of nonzero cnt.
- flush:
  - The ID instruction is neither accepted nor stalled, and no counter is written.
  - Counters of older instructions keep counting.
  - flush with issue_valid=0 has no effect.
- A source equal to the destination of the same instruction is checked against the old counter. The instruction's own write does not cause a self-stall.
- There is no combinational path from stall to any input.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- When defined: stall_cycles is a 32-bit counter that increments on every cycle with stall=1. It wraps from 0xFFFFFFFF to 0 and is cleared by reset.
- When undefined: no counter is built and stall_cycles is tied to 0. The port stays present so top-level wiring is unchanged.

Test Plan:
- Reset: hold reset=0 for 2 cycles during pending writes, then release -> stall=0, busy_count=0, fwd dists=0.
- Load-use: accept rd=5 lat=3 at cycle t; at t+1 present rs=5 -> stall=1 at t+1; accept at t+2 with fwd_rs_dist=2; cnt[5] reaches 0 at t+4.
- Register zero: accept rd=0 lat=4, then read rs=0 -> busy_count stays 0, no stall, fwd_rs_dist=0.
- WAW: accept rd=7 lat=4, next cycle rd=7 lat=1 -> stall for 4 cycles, accepted when cnt[7]=0, cnt[7]=1 the cycle after.
- Flush: issue rd=9 lat=3 with flush=1 -> cnt[9] stays 0, stall=0; an independent pending cnt[4]=2 still decrements to 1.
- Stats (SCOREBOARD_STATS_EN): the load-use plus WAW sequence -> stall_cycles=5; without the macro -> stall_cycles=0.
